// File: rtl/cond_unit_pkg.sv
// Shared encodings for the condition/flag stage: ARM condition codes, NZCV bit
// positions and the controller's FlagW encodings.
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FLAGW_NONE = 2'b00;
  localparam logic [1:0] FLAGW_NZ   = 2'b10;
  localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: decides whether an instruction
// with condition field cond_i executes given the NZCV word flags_i.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v, ge;

  assign n  = flags_i[FLAG_N];
  assign z  = flags_i[FLAG_Z];
  assign c  = flags_i[FLAG_C];
  assign v  = flags_i[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    pass_o = 1'b1;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = ge;
      COND_LT: pass_o = ~ge;
      COND_GT: pass_o = ~z & ge;
      COND_LE: pass_o = z | ~ge;
      // AL and the 1111 encoding both execute unconditionally.
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition/flag stage after the ALU: registers ALUOut, holds NZCV, latches the
// condition outcome in Decode and gates the architectural write strobes with it.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [3:0]       ALUFlags,
  input  logic [3:0]       Cond,
  input  logic             CondLatch,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite
);

  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       flags_q, flags_d;
  logic             cond_ex_q, cond_ex_d;
  logic             cond_pass;
  logic [1:0]       flag_write;

  cond_check u_cond_check (
    .cond_i  (Cond),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  // Flag writes use the held outcome, so a same-edge CondLatch cannot affect them.
  assign flag_write = FlagW & {2{cond_ex_q}};

  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (flag_write[0]) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  assign cond_ex_d = CondLatch ? cond_pass : cond_ex_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_out_q <= '0;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      alu_out_q <= ALUResult;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign ALUOut   = alu_out_q;
  assign Flags    = flags_q;
  assign CondEx   = cond_ex_q;

  // Fetch increments bypass the condition so instruction fetch is never suppressed.
  assign PCWrite  = (PCS & cond_ex_q) | NextPC;
  assign RegWrite = RegW & cond_ex_q;
  assign MemWrite = MemW & cond_ex_q;

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Condition/flag stage directly downstream of the ALU in the multi-cycle ARM datapath.
- Registers the ALU result (ALUOut), holds the NZCV status register and evaluates the instruction condition field against it.
- Gates the controller's architectural write strobes (PC, register file, memory, flags) so that non-executed instructions have no side effects.

Parameters:
- WIDTH, 32, datapath width of ALU result and ALUOut register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ALUResult  in  WIDTH  ALU result, captured every cycle.
- ALUFlags  in  4  {N,Z,C,V} from ALU, same bit order as Flags.
- Cond  in  4  instruction bits [31:28].
- CondLatch  in  1  controller pulse in Decode state; samples the condition outcome.
- FlagW  in  2  [1]=update N,Z; [0]=update C,V (controller, Execute state).
- PCS  in  1  instruction writes PC (branch or Rd=R15).
- NextPC  in  1  unconditional PC increment (Fetch).
- RegW  in  1  register-file write request.
- MemW  in  1  memory write request.
- ALUOut  out  WIDTH  registered ALUResult.
- Flags  out  4  current {N,Z,C,V}.
- CondEx  out  1  registered condition outcome of the current instruction.
- PCWrite  out  1  gated PC write enable.
- RegWrite  out  1  gated register write enable.
- MemWrite  out  1  gated memory write enable.

Behaviour:
- Reset (async, reset=0): ALUOut=0, Flags=4'b0000, CondEx=0. PCWrite, RegWrite and MemWrite are therefore 0 unless NextPC=1.
- ALUOut: on every rising edge, ALUOut <= ALUResult. One-cycle latency, no enable.
- Condition evaluation (combinational on registered Flags):
  - EQ 0000: Z. NE 0001: ~Z.
  - CS 0010: C. CC 0011: ~C.
  - MI 0100: N. PL 0101: ~N.
  - VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1. 1111: 1 (treated as unconditional).
- CondEx register:
  - Loads the evaluated condition on a rising edge with CondLatch=1.
  - Otherwise holds its value.
  - Holding guarantees that a flag update in Execute does not change the outcome for the remainder of the same instruction.
- Flags register:
  - FlagWrite[1] = FlagW[1] & CondEx: updates Flags[3:2] from ALUFlags[3:2] on that edge.
  - FlagWrite[0] = FlagW[0] & CondEx: updates Flags[1:0] from ALUFlags[1:0].
  - The two halves are independent: a logical S-instruction may update NZ only.
- Gated strobes (combinational, no added latency):
  - PCWrite = (PCS & CondEx) | NextPC.
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
- Simultaneous events:
  - CondLatch=1 and FlagW!=0 in the same cycle: the flag update uses the old CondEx. The new CondEx is computed from the old Flags; flags written that edge are not visible until the next cycle.
  - NextPC=1 with CondEx=0: PCWrite=1 (fetch is never suppressed).
- Reset mid-instruction: all state is cleared immediately. After release, CondEx=0 until the next CondLatch, so no spurious RegWrite or MemWrite.
- No X propagation: every register has a defined reset value and every case branch is covered.

Decomposition:
- Shared package:
  - Condition-code constants COND_EQ…COND_AL (4'h0…4'hE).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW encodings FLAGW_NONE=2'b00, FLAGW_NZ=2'b10, FLAGW_ALL=2'b11.
- One sub-module: cond_check, purely combinational (Cond, Flags → pass). It can be reused by a future predicated-decode stage.
- cond_unit holds the ALUOut, Flags and CondEx registers and the strobe gating.

Test Plan:
- Reset: assert reset=0 mid-run with Flags=4'b1111 → ALUOut=0, Flags=0, CondEx=0 immediately. With RegW=MemW=PCS=1, NextPC=0 → all three strobes 0.
- Flag update:
  - Cond=AL, CondLatch pulse, then FlagW=2'b11 with ALUFlags=4'b0110 → next cycle Flags=4'b0110.
  - Then FlagW=2'b10 with ALUFlags=4'b1001 → Flags=4'b1010 (CV retained).
- Condition sweep: for each of the 16 Cond values, preload all 16 Flags patterns, pulse CondLatch → CondEx matches the condition table (256 checks).
- Suppression: Flags=4'b0000, Cond=EQ, CondLatch, then RegW=1, MemW=1, PCS=1, FlagW=2'b11 → RegWrite=MemWrite=PCWrite=0 and Flags unchanged. NextPC=1 alone → PCWrite=1.
- Same-edge hazard:
  - Flags=Z set, Cond=EQ latched (CondEx=1).
  - Execute with FlagW=2'b11, ALUFlags=0 and CondLatch=1 (Cond=NE) on the same edge → Flags=0 and CondEx=0 (computed from old Z=1).
- ALUOut: drive ALUResult=32'hDEADBEEF, then 32'h00000001 on consecutive cycles → ALUOut follows with exactly one-cycle latency.
